// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between the VGA timing controller and the pixel path.
interface vga_timing_ctrl_if;
    logic       en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hblank;
    logic       vblank;
    logic       hsync;
    logic       vsync;
    logic       pix_en;
    logic       line_start;
    logic       frame_start;
    logic       busy;

    modport master (
        input  en,
        output hcount, vcount, hblank, vblank, hsync, vsync,
        output pix_en, line_start, frame_start, busy
    );

    modport slave (
        output en,
        input  hcount, vcount, hblank, vblank, hsync, vsync,
        input  pix_en, line_start, frame_start, busy
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster scheduler: pixel-clock enable, h/v counters, registered blank/sync
// decodes and a start/stop FSM that only idles on a whole-frame boundary.
module vga_timing_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int CLK_DIV         = 4,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_ctrl_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_timing_ctrl: H_TOTAL %0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_ctrl: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_timing_ctrl: CLK_DIV %0d outside 1..16", CLK_DIV);
    end

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit thresholds so an active width of exactly 1024 still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] div_q, div_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    logic       pix_en;
    logic       h_last;
    logic       v_last;
    logic       hs_window;
    logic       vs_window;

    assign pix_en = (state_q != IDLE) && (div_q == DIV_LAST);
    assign h_last = (hcnt_q == H_LAST);
    assign v_last = (vcnt_q == V_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;

        unique case (state_q)
            IDLE:     if (vga.en) state_d = RUN;
            RUN:      if (!vga.en) state_d = STOPPING;
            STOPPING: begin
                if (vga.en) begin
                    state_d = RUN;
                end else if (pix_en && h_last && v_last) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
            if (pix_en) begin
                if (h_last) begin
                    hcnt_d = '0;
                    vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
                end else begin
                    hcnt_d = hcnt_q + 10'd1;
                end
            end
        end

        if (state_d == IDLE) begin
            div_d  = '0;
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    // Decodes are taken from the next-state counters so the registered
    // blank/sync outputs line up with the counter values they describe.
    always_comb begin
        hs_window = ({1'b0, hcnt_d} >= HS_BEG) && ({1'b0, hcnt_d} < HS_END);
        vs_window = ({1'b0, vcnt_d} >= VS_BEG) && ({1'b0, vcnt_d} < VS_END);
        hblank_d  = (state_d == IDLE) || ({1'b0, hcnt_d} >= H_VIS);
        vblank_d  = (state_d == IDLE) || ({1'b0, vcnt_d} >= V_VIS);
        hsync_d   = ((state_d != IDLE) && hs_window) ? SYNC_ON : ~SYNC_ON;
        vsync_d   = ((state_d != IDLE) && vs_window) ? SYNC_ON : ~SYNC_ON;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hsync_q  <= ~SYNC_ON;
            vsync_q  <= ~SYNC_ON;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign vga.hcount      = hcnt_q;
    assign vga.vcount      = vcnt_q;
    assign vga.hblank      = hblank_q;
    assign vga.vblank      = vblank_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.pix_en      = pix_en;
    assign vga.line_start  = pix_en && (hcnt_q == '0);
    assign vga.frame_start = pix_en && (hcnt_q == '0) && (vcnt_q == '0);
    assign vga.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: three modes driven with random run/stop
// requests, checked against a frame-position reference model.
module tb_vga_timing_ctrl;
    localparam int NDUT      = 3;
    localparam int NCYC      = 15000;
    localparam int PULSE_CYC = 5200;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } rec_t;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int div;
        bit low;
    } cfg_t;

    cfg_t cfg [NDUT] = '{
        '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b1},
        '{16,  4,  6,  6,  8,   2,  2, 3,  3, 1'b1},
        '{8,   2,  2,  2,  4,   1,  1, 1,  1, 1'b0}
    };

    logic clk = 1'b0;
    logic rst_a [NDUT] = '{1'b0, 1'b0, 1'b0};
    logic en_a  [NDUT] = '{1'b1, 1'b1, 1'b1};
    rec_t obs    [NDUT];
    logic busy_o [NDUT];
    logic pix_o  [NDUT];

    bit   m_act  [NDUT];
    bit   m_stop [NDUT];
    bit   m_pix  [NDUT];
    int   m_c    [NDUT];
    int   m_fs_exp [NDUT];
    rec_t exp_q  [NDUT][$];
    int   fs_obs [NDUT];

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   done   = 1'b0;
    int   left [NDUT] = '{0, 2000, 200};

    always #5 clk = ~clk;

    vga_timing_ctrl_if bus0 ();
    vga_timing_ctrl_if bus1 ();
    vga_timing_ctrl_if bus2 ();

    vga_timing_ctrl #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .CLK_DIV(4), .SYNC_ACTIVE_LOW(1'b1)
    ) u_dut0 (.clk(clk), .rst(rst_a[0]), .vga(bus0.master));

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(3), .SYNC_ACTIVE_LOW(1'b1)
    ) u_dut1 (.clk(clk), .rst(rst_a[1]), .vga(bus1.master));

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_ACTIVE_LOW(1'b0)
    ) u_dut2 (.clk(clk), .rst(rst_a[2]), .vga(bus2.master));

    assign bus0.en = en_a[0];
    assign bus1.en = en_a[1];
    assign bus2.en = en_a[2];
    assign obs[0] = {bus0.hcount, bus0.vcount, bus0.hblank, bus0.vblank,
                     bus0.hsync, bus0.vsync, bus0.line_start, bus0.frame_start};
    assign obs[1] = {bus1.hcount, bus1.vcount, bus1.hblank, bus1.vblank,
                     bus1.hsync, bus1.vsync, bus1.line_start, bus1.frame_start};
    assign obs[2] = {bus2.hcount, bus2.vcount, bus2.hblank, bus2.vblank,
                     bus2.hsync, bus2.vsync, bus2.line_start, bus2.frame_start};
    assign busy_o[0] = bus0.busy;
    assign busy_o[1] = bus1.busy;
    assign busy_o[2] = bus2.busy;
    assign pix_o[0]  = bus0.pix_en;
    assign pix_o[1]  = bus1.pix_en;
    assign pix_o[2]  = bus2.pix_en;

    function automatic int h_total(int d);
        return cfg[d].ha + cfg[d].hfp + cfg[d].hs + cfg[d].hbp;
    endfunction

    function automatic int v_total(int d);
        return cfg[d].va + cfg[d].vfp + cfg[d].vs + cfg[d].vbp;
    endfunction

    function automatic rec_t idle_rec(int d);
        rec_t r;
        r.h  = '0;
        r.v  = '0;
        r.hb = 1'b1;
        r.vb = 1'b1;
        r.hs = cfg[d].low;
        r.vs = cfg[d].low;
        r.ls = 1'b0;
        r.fs = 1'b0;
        return r;
    endfunction

    // Expected outputs while the raster shows pixel index p of the frame.
    function automatic rec_t expect_at(int d, int p);
        rec_t r;
        int   h   = p % h_total(d);
        int   v   = p / h_total(d);
        logic on  = cfg[d].low ? 1'b0 : 1'b1;
        int   hsb = cfg[d].ha + cfg[d].hfp;
        int   vsb = cfg[d].va + cfg[d].vfp;
        r.h  = 10'(h);
        r.v  = 10'(v);
        r.hb = (h >= cfg[d].ha);
        r.vb = (v >= cfg[d].va);
        r.hs = (h >= hsb && h < hsb + cfg[d].hs) ? on : ~on;
        r.vs = (v >= vsb && v < vsb + cfg[d].vs) ? on : ~on;
        r.ls = (h == 0);
        r.fs = (h == 0) && (v == 0);
        return r;
    endfunction

    // m_c counts clk cycles since entering RUN, modulo one frame period.
    function automatic void model_step(int d);
        int dv  = cfg[d].div;
        int fp  = h_total(d) * v_total(d);
        bit tk  = (m_c[d] % dv) == dv - 1;
        int p   = m_c[d] / dv;
        rec_t r;
        if (!m_act[d]) begin
            if (en_a[d]) begin
                m_act[d]  = 1'b1;
                m_stop[d] = 1'b0;
                m_c[d]    = 0;
            end
        end else if (m_stop[d] && !en_a[d] && tk && p == fp - 1) begin
            m_act[d] = 1'b0;
        end else begin
            m_c[d]    = (m_c[d] + 1) % (dv * fp);
            m_stop[d] = !en_a[d];
        end
        m_pix[d] = m_act[d] && ((m_c[d] % dv) == dv - 1);
        if (m_pix[d]) begin
            r = expect_at(d, m_c[d] / dv);
            exp_q[d].push_back(r);
            if (r.fs) m_fs_exp[d]++;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_a[0]);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst_a[d]) begin
                    m_act[d]  = 1'b0;
                    m_stop[d] = 1'b0;
                    m_pix[d]  = 1'b0;
                    exp_q[d].delete();
                end else if (clk) begin
                    model_step(d);
                end
            end
        end
    end

    function automatic void chk(string what, int d, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", what, d, act, exp, $time);
        end
    endfunction

    function automatic void check_cycle(int d);
        chk("busy", d, 32'(busy_o[d]), 32'(m_act[d]));
        chk("pix_en", d, 32'(pix_o[d]), 32'(m_pix[d]));
        if (pix_o[d]) begin
            if (obs[d].fs) fs_obs[d]++;
            if (exp_q[d].size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL tick dut%0d: got tick 0x%0h, expected no tick (t=%0t)", d, obs[d], $time);
            end else begin
                chk("tick outputs", d, 32'(obs[d]), 32'(exp_q[d].pop_front()));
            end
        end else begin
            chk("pulses off-tick", d, 32'({obs[d].ls, obs[d].fs}), 32'd0);
        end
        if (!m_act[d]) chk("idle outputs", d, 32'(obs[d]), 32'(idle_rec(d)));
    endfunction

    initial begin
        bit rst0_prev = 1'b0;
        while (!done) begin
            @(negedge clk or negedge rst_a[0]);
            if (rst_a[0] === 1'b0 && rst0_prev) begin
                rst0_prev = 1'b0;
                #1;
                chk("async reset busy", 0, 32'(busy_o[0]), 32'(m_act[0]));
                chk("async reset pix_en", 0, 32'(pix_o[0]), 32'(m_pix[0]));
                chk("async reset outputs", 0, 32'(obs[0]), 32'(idle_rec(0)));
            end else begin
                rst0_prev = rst_a[0];
                for (int d = 0; d < NDUT; d++) check_cycle(d);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk("queue drained", d, 32'(exp_q[d].size()), 32'd0);
            chk("frame_start count", d, 32'(fs_obs[d]), 32'(m_fs_exp[d]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    function automatic int pick_len(int d);
        if ($urandom_range(0, 3) == 0)
            return (d == 1) ? int'($urandom_range(200, 2000)) : int'($urandom_range(20, 200));
        return (d == 1) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 8));
    endfunction

    initial begin
        repeat (5) @(negedge clk);
        rst_a = '{1'b1, 1'b1, 1'b1};
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == PULSE_CYC) begin
                #1 rst_a[0] = 1'b0;
                #2 rst_a[0] = 1'b1;
            end
            for (int d = 1; d < NDUT; d++) begin
                if (left[d] == 0) begin
                    en_a[d] = !en_a[d];
                    left[d] = pick_len(d);
                end else begin
                    left[d]--;
                end
            end
        end
        done = 1'b1;
    end
endmodule
